// File: rtl/udma_l2_port_arbiter_pkg.sv
// Shared configuration for the uDMA L2 port arbiter: default sizes and the requester ID type.
`timescale 1ns/1ps
package udma_cfg_pkg;
  localparam int CFG_N_REQ         = 4;
  localparam int CFG_MAX_OUTST     = 4;
  localparam int CFG_L2_DATA_WIDTH = 32;

  localparam int ARB_ID_W = $clog2(CFG_N_REQ);
  typedef logic [ARB_ID_W-1:0] arb_id_t;
endpackage

// File: rtl/udma_l2_port_arbiter_if.sv
// Request/grant/response bundle for an L2-style memory port; N lanes share one rdata bus.
`timescale 1ns/1ps
interface udma_l2_port_arbiter_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N-1:0]                   req;
  logic [N-1:0]                   gnt;
  logic [N-1:0]                   wen;
  logic [N-1:0][31:0]             addr;
  logic [N-1:0][DATA_WIDTH-1:0]   wdata;
  logic [N-1:0][DATA_WIDTH/8-1:0] be;
  logic [N-1:0]                   rvalid;
  logic [DATA_WIDTH-1:0]          rdata;

  modport master (output req, wen, addr, wdata, be, input  gnt, rvalid, rdata);
  modport slave  (input  req, wen, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/udma_l2_arb_id_fifo.sv
// In-order FIFO of granted requester IDs awaiting their L2 response.
`timescale 1ns/1ps
module udma_l2_arb_id_fifo
  import udma_cfg_pkg::*;
#(
  parameter int DEPTH = CFG_MAX_OUTST
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  arb_id_t data_i,
  input  logic    pop_i,
  output arb_id_t data_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  arb_id_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/udma_l2_port_arbiter.sv
// Round-robin arbiter sharing one uDMA L2 port; routes in-order responses back to the requester.
// Optional build macro UDMA_L2_ARB_PRIO_EN gives requester 0 fixed priority over the round-robin.
`timescale 1ns/1ps
module udma_l2_port_arbiter
  import udma_cfg_pkg::*;
#(
  parameter int N_REQ      = CFG_N_REQ,
  parameter int MAX_OUTST  = CFG_MAX_OUTST,
  parameter int DATA_WIDTH = CFG_L2_DATA_WIDTH
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_ni,
  udma_l2_port_arbiter_if.slave    req_bus,
  udma_l2_port_arbiter_if.master   l2_bus,
  output logic                     err_o
);
  arb_id_t            rr_ptr;
  arb_id_t            rr_winner;
  arb_id_t            winner;
  arb_id_t            lock_id;
  arb_id_t            head_id;
  logic               lock;
  logic               any_req;
  logic               l2_req;
  logic               hs;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [N_REQ-1:0]   gnt_vec;
  logic [N_REQ-1:0]   rvalid_vec;

  always_comb begin
    rr_winner = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req_bus.req[idx]) rr_winner = arb_id_t'(idx);
    end
  end

  // A held (locked) winner overrides everything so a stalled request stays stable.
  always_comb begin
    winner = rr_winner;
`ifdef UDMA_L2_ARB_PRIO_EN
    if (req_bus.req[0]) winner = '0;
`endif
    if (lock) winner = lock_id;
  end

  assign any_req = |req_bus.req;
  assign l2_req  = any_req & ~fifo_full & sys_rst_ni;
  assign hs      = l2_req & l2_bus.gnt[0];
  assign pop     = l2_bus.rvalid[0] & ~fifo_empty & sys_rst_ni;

  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    if (hs)  gnt_vec[winner]     = 1'b1;
    if (pop) rvalid_vec[head_id] = 1'b1;
  end

  assign req_bus.gnt    = gnt_vec;
  assign req_bus.rvalid = rvalid_vec;
  assign req_bus.rdata  = l2_bus.rdata;

  assign l2_bus.req      = l2_req;
  assign l2_bus.wen      = any_req ? req_bus.wen[winner]   : 1'b1;
  assign l2_bus.addr[0]  = any_req ? req_bus.addr[winner]  : '0;
  assign l2_bus.wdata[0] = any_req ? req_bus.wdata[winner] : '0;
  assign l2_bus.be[0]    = any_req ? req_bus.be[winner]    : '0;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      err_o   <= 1'b0;
    end else begin
      if (hs) begin
        lock <= 1'b0;
`ifdef UDMA_L2_ARB_PRIO_EN
        if (winner != '0)
`endif
          rr_ptr <= (winner == arb_id_t'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end else if (l2_req) begin
        lock    <= 1'b1;
        lock_id <= winner;
      end
      if (l2_bus.rvalid[0] && fifo_empty) err_o <= 1'b1;
    end
  end

  udma_l2_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) i_id_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rst_ni),
    .push_i  (hs),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule
